keypad_scanner: RTL and testbench

- Front-panel input stage directly upstream of the microwave top level.
- Scans a 4x4 active-low membrane matrix, synchronizes and debounces it, and rejects multi-key presses.
- Drives the top level's 10-bit one-hot digit bus `keypad[9:0]` and its active-low `startn`/`stopn`/`clearn` command inputs, all glitch-free and in the `clk` domain.

---
 rtl/keypad_scanner.sv | 221 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 membrane keypad scanner with debounce and multi-key rejection.
// Define KEY_PULSE_EN to make keypad[k] a one-clk pulse on acceptance instead of a level.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [9:0] keypad,
    output logic       startn,
    output logic       stopn,
    output logic       clearn,
    output logic       key_valid
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [3:0] K_START = 4'd10;
    localparam logic [3:0] K_STOP  = 4'd11;
    localparam logic [3:0] K_CLEAR = 4'd12;
    localparam logic [3:0] K_NONE  = 4'd15;

    typedef enum logic {ST_STABLE, ST_PENDING} db_state_t;

    function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'd0:    return 4'd1;
            4'd1:    return 4'd2;
            4'd2:    return 4'd3;
            4'd3:    return K_START;
            4'd4:    return 4'd4;
            4'd5:    return 4'd5;
            4'd6:    return 4'd6;
            4'd7:    return K_STOP;
            4'd8:    return 4'd7;
            4'd9:    return 4'd8;
            4'd10:   return 4'd9;
            4'd11:   return K_CLEAR;
            4'd13:   return 4'd0;
            default: return K_NONE;
        endcase
    endfunction

    logic [3:0]    row_s1, row_s2;
    logic [CW-1:0] div_cnt;
    logic [1:0]    col;
    logic          last_tick, scan_done;
    logic [2:0]    col_hits, tot;
    logic [3:0]    col_id, scan_code;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_id;

    db_state_t     state_q, state_d;
    logic [3:0]    cand_q, cand_d, acc_key_q, acc_key_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    logic [9:0]    keypad_d;
    logic          startn_d, stopn_d, clearn_d, show_digit;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
        end
    end

    assign last_tick = (div_cnt == CW'(SCAN_DIV - 1));
    assign scan_done = last_tick && (col == 2'd3);

    // Column drive is a rotating register so the pins never glitch through a decoder.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            div_cnt <= '0;
            col     <= 2'd0;
            col_n   <= 4'b1110;
        end else if (last_tick) begin
            div_cnt <= '0;
            col     <= col + 2'd1;
            col_n   <= {col_n[2:0], col_n[3]};
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    always_comb begin
        col_hits = 3'd0;
        col_id   = K_NONE;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r] && key_at(2'(r), col) != K_NONE) begin
                col_hits = col_hits + 3'd1;
                col_id   = key_at(2'(r), col);
            end
        end
        tot = 3'(acc_cnt) + col_hits;
        if (tot == 3'd1)
            scan_code = (acc_cnt == 2'd1) ? acc_id : col_id;
        else
            scan_code = K_NONE;
    end

    // Key count saturates at 2: anything beyond one key is simply MULTI, reported as NONE.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            acc_cnt <= 2'd0;
            acc_id  <= K_NONE;
        end else if (last_tick) begin
            if (col == 2'd3) begin
                acc_cnt <= 2'd0;
                acc_id  <= K_NONE;
            end else begin
                acc_cnt <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
                acc_id  <= (acc_cnt != 2'd0) ? acc_id : col_id;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= ST_STABLE;
            cand_q    <= K_NONE;
            acc_key_q <= K_NONE;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            acc_key_q <= acc_key_d;
            dcnt_q    <= dcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        acc_key_d = acc_key_q;
        dcnt_d    = dcnt_q;
        if (scan_done) begin
            case (state_q)
                ST_STABLE: begin
                    if (scan_code != acc_key_q) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            acc_key_d = scan_code;
                        end else begin
                            state_d = ST_PENDING;
                            cand_d  = scan_code;
                            dcnt_d  = DW'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (scan_code == cand_q) begin
                        if (dcnt_q + DW'(1) == DW'(DEBOUNCE_SCANS)) begin
                            acc_key_d = cand_q;
                            state_d   = ST_STABLE;
                        end else begin
                            dcnt_d = dcnt_q + DW'(1);
                        end
                    end else if (scan_code == acc_key_q) begin
                        state_d = ST_STABLE;
                    end else begin
                        cand_d = scan_code;
                        dcnt_d = DW'(1);
                    end
                end
                default: state_d = ST_STABLE;
            endcase
        end
    end

`ifdef KEY_PULSE_EN
    logic [3:0] acc_prev_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            acc_prev_q <= K_NONE;
        else
            acc_prev_q <= acc_key_q;
    end

    assign show_digit = (acc_key_q != acc_prev_q);
`else
    assign show_digit = 1'b1;
`endif

    always_comb begin
        keypad_d = 10'd0;
        startn_d = 1'b1;
        stopn_d  = 1'b1;
        clearn_d = 1'b1;
        if (acc_key_q <= 4'd9 && show_digit)
            keypad_d = 10'd1 << acc_key_q;
        case (acc_key_q)
            K_START: startn_d = 1'b0;
            K_STOP:  stopn_d  = 1'b0;
            K_CLEAR: clearn_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            keypad    <= 10'd0;
            startn    <= 1'b1;
            stopn     <= 1'b1;
            clearn    <= 1'b1;
            key_valid <= 1'b0;
        end else begin
            keypad    <= keypad_d;
            startn    <= startn_d;
            stopn     <= stopn_d;
            clearn    <= clearn_d;
            key_valid <= (acc_key_q != K_NONE);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized keypad scanner bench against a per-scan behavioural model.
module tb_keypad_scanner;

    localparam int D = 2;

    logic       clk = 1'b0;
    logic       clrn;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [9:0] keypad;
    logic       startn, stopn, clearn, key_valid;

    logic [15:0] pressed;
    int checks = 0;
    int errors = 0;

    int key_of[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, -1, 0, -1, -1};
    int hist[$];
    int accepted;
    int pulse_key;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(D)) dut (
        .clk(clk), .clrn(clrn), .row_n(row_n), .col_n(col_n), .keypad(keypad),
        .startn(startn), .stopn(stopn), .clearn(clearn), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // Physical matrix: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int scan_code(input logic [15:0] p);
        int n = 0;
        int id = -1;
        for (int i = 0; i < 16; i++)
            if (p[i] && key_of[i] >= 0) begin
                n++;
                id = key_of[i];
            end
        return (n == 1) ? id : -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        accepted  = -1;
        pulse_key = -1;
    endtask

    // A new key is accepted once the last D scans all agree on it.
    task automatic model_scan(input int code);
        int prev = accepted;
        bit agree = 1;
        hist.push_back(code);
        if (hist.size() > D) void'(hist.pop_front());
        foreach (hist[i]) if (hist[i] != code) agree = 0;
        if (hist.size() == D && agree && code != accepted) accepted = code;
        pulse_key = (accepted != prev && accepted >= 0 && accepted <= 9) ? accepted : -1;
    endtask

    function automatic logic [13:0] exp_out(input bit first);
        logic [9:0] kp = 10'd0;
`ifdef KEY_PULSE_EN
        if (first && pulse_key >= 0) kp = 10'd1 << pulse_key;
`else
        if (accepted >= 0 && accepted <= 9) kp = 10'd1 << accepted;
`endif
        return {kp, accepted != 10, accepted != 11, accepted != 12, accepted != -1};
    endfunction

    task automatic check_cycle(input string tag, input bit first);
        int act = $countones({keypad, ~startn, ~stopn, ~clearn});
        check(tag, {keypad, startn, stopn, clearn, key_valid}, exp_out(first));
        check("onehot", act <= 1, 1);
    endtask

    // Entered at the negedge where column 0 has just become driven; leaves at the next one.
    task automatic run_scan(input logic [15:0] p);
        pressed = p;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check_cycle("outputs", i == 1);
        end
        check("scan_align", col_n, 4'b1110);
        model_scan(scan_code(p));
    endtask

    task automatic hold(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) run_scan(p);
    endtask

    task automatic assert_reset();
        clrn = 1'b0;
        model_reset();
        #1;
        check("reset_out", {keypad, startn, stopn, clearn, key_valid}, {10'd0, 4'b1110});
        check("reset_col", col_n, 4'b1110);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_col;
        logic [15:0] p;
        int kind;
        pressed = 16'd0;
        clrn    = 1'b1;
        @(negedge clk);
        assert_reset();

        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            exp_col = ~(4'b0001 << (i / 4));
            check("col_seq", col_n, exp_col);
            check_cycle("idle", i == 1);
        end
        @(negedge clk);
        check("col_wrap", col_n, 4'b1110);
        model_scan(-1);

        hold(16'd1 << 5, 5);
        hold(16'd0, 3);
        hold(16'd1 << 8, 1);
        hold(16'd0, 3);
        hold((16'd1 << 3) | (16'd1 << 2), 3);
        hold(16'd1 << 3, 3);
        hold(16'd0, 3);
        hold(16'd1 << 13, 3);
        hold(16'd1 << 11, 3);
        hold(16'd0, 3);
        hold(16'd1 << 1, 10);
        hold(16'd0, 3);

        hold(16'd1 << 5, 3);
        run_scan(16'd1 << 10);
        repeat (5) @(negedge clk);
        assert_reset();
        hold(16'd1 << 10, 3);
        hold(16'd0, 3);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: p = 16'd0;
                1: p = 16'd1 << $urandom_range(0, 15);
                2: p = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
                default: p = 16'd1 << (($urandom_range(0, 1) == 0) ? $urandom_range(0, 11) : 13);
            endcase
            hold(p, $urandom_range(1, 4));
        end
        hold(16'd0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
